// File: rtl/sm_debug_dump.sv
// Debug-port dumper for schoolMIPS: walks the register file (PC at index 0) and
// data RAM, streaming each 32-bit word as an uppercase ASCII hex line.
module sm_debug_dump #(
    parameter int unsigned MEM_COUNT = 16,
    parameter logic [7:0]  EOL       = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [3:0]  memAddr,
    input  logic [31:0] memData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    localparam logic [5:0] LAST_IDX = 6'(31 + MEM_COUNT);

    state_t      state, stateNext;
    logic [5:0]  idx;
    logic [5:0]  idxNext;
    logic [3:0]  nib;
    logic [31:0] word;
    logic [3:0]  curNibble;
    logic        fire;
    logic        eolByte;
    logic        lastWord;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Bit index 31-4*nib for nib 0..7 is just {~nib, 2'b11}.
    assign curNibble = word[{~nib[2:0], 2'b11} -: 4];
    assign eolByte   = (nib == 4'd8);
    assign lastWord  = (idx == LAST_IDX);
    assign idxNext   = idx + 6'd1;
    assign fire      = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        tx_valid  = 1'b0;
        tx_data   = '0;
        case (state)
            IDLE:    if (start) stateNext = CAPTURE;
            CAPTURE: stateNext = SEND;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = eolByte ? EOL : hexChar(curNibble);
                if (fire && eolByte)
                    stateNext = lastWord ? IDLE : CAPTURE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            nib     <= '0;
            word    <= '0;
            regAddr <= '0;
            memAddr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        regAddr <= '0;
                        memAddr <= '0;
                        busy    <= 1'b1;
                    end
                end
                CAPTURE: begin
                    word <= idx[5] ? memData : regData;
                    nib  <= '0;
                end
                SEND: begin
                    if (fire) begin
                        nib <= nib + 4'd1;
                        if (eolByte) begin
                            if (lastWord) begin
                                nib  <= '0;
                                busy <= 1'b0;
                                done <= 1'b1;
                            end else begin
                                // Addresses move only on the edge into CAPTURE.
                                idx     <= idxNext;
                                regAddr <= idxNext[5] ? 5'd0 : idxNext[4:0];
                                memAddr <= idxNext[5] ? idxNext[3:0] : 4'd0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_debug_dump.sv
// Bench for sm_debug_dump: scenario table plus hand sequences, streams checked
// against a reference formatter built directly from the dump rules.
module tb_sm_debug_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        startA, startB;
    logic        txReady;
    logic [4:0]  regAddrA, regAddrB;
    logic [3:0]  memAddrA, memAddrB;
    logic [31:0] regDataA, regDataB, memDataA, memDataB;
    logic [7:0]  txDataA, txDataB;
    logic        txValidA, txValidB, busyA, busyB, doneA, doneB;

    logic [31:0] regArr [32];
    logic [31:0] memArr [16];

    always #5 clk = ~clk;

    assign regDataA = regArr[regAddrA];
    assign memDataA = memArr[memAddrA];
    assign regDataB = regArr[regAddrB];
    assign memDataB = memArr[memAddrB];

    sm_debug_dump #(.MEM_COUNT(16), .EOL(8'h0A)) dutA (
        .clk(clk), .rst(rst), .start(startA),
        .regAddr(regAddrA), .regData(regDataA),
        .memAddr(memAddrA), .memData(memDataA),
        .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReady),
        .busy(busyA), .done(doneA)
    );

    sm_debug_dump #(.MEM_COUNT(1), .EOL(8'h0A)) dutB (
        .clk(clk), .rst(rst), .start(startB),
        .regAddr(regAddrB), .regData(regDataB),
        .memAddr(memAddrB), .memData(memDataB),
        .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReady),
        .busy(busyB), .done(doneB)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] rx [$];

    typedef struct {
        string name;
        bit    useB;
        int    readyPct;
        bit    randData;
        bit    midStart;
        int    memCount;
        int    expBytes;
        int    expDone;
    } scen_t;

    typedef struct {
        int    ln;
        string txt;
    } line_t;

    scen_t scen [6];
    line_t lines [5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic checkStr(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic loadData(input bit randData);
        for (int i = 0; i < 32; i++)
            regArr[i] = randData ? $urandom : (i == 0 ? 32'h0000_0010 : (32'hDEAD_0000 | 32'(i)));
        for (int i = 0; i < 16; i++)
            memArr[i] = randData ? $urandom : 32'h0123_ABEF;
    endtask

    function automatic logic [7:0] hexOf(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Reference stream: register words 0..31 then RAM words 0..memCount-1.
    task automatic buildExpected(input int memCount, output logic [7:0] exp [$]);
        logic [31:0] v;
        exp.delete();
        for (int w = 0; w < 32 + memCount; w++) begin
            v = (w < 32) ? regArr[w] : memArr[w - 32];
            for (int k = 0; k < 8; k++)
                exp.push_back(hexOf(int'((v >> (28 - 4 * k)) & 32'hF)));
            exp.push_back(8'h0A);
        end
    endtask

    task automatic runDump(input int si);
        scen_t s;
        logic [7:0] exp [$];
        int c, tail, doneCnt, doneCyc, stallViol, memViol, mism, eols;
        logic v, d, b, prevStall, rdy;
        logic [7:0] dat, prevDat;
        s = scen[si];
        loadData(s.randData);
        rx.delete();
        doneCnt = 0; doneCyc = -1; stallViol = 0; memViol = 0; tail = -1;
        prevStall = 1'b0; prevDat = '0;
        @(negedge clk);
        txReady = 1'b0;
        if (s.useB) startB = 1'b1; else startA = 1'b1;
        @(posedge clk);
        #1 startA = 1'b0; startB = 1'b0;
        c = 0;
        while (c < 6000) begin
            @(negedge clk);
            v   = s.useB ? txValidB : txValidA;
            dat = s.useB ? txDataB  : txDataA;
            d   = s.useB ? doneB    : doneA;
            if (s.useB && memAddrB != 4'd0) memViol++;
            if (prevStall && (!v || dat != prevDat)) stallViol++;
            if (d) begin
                doneCnt++;
                doneCyc = c;
                if (tail < 0) tail = c;
            end
            if (tail >= 0 && c >= tail + 20) break;
            rdy = ($urandom_range(99) < s.readyPct);
            txReady = rdy;
            if (v && rdy) rx.push_back(dat);
            prevStall = v && !rdy;
            prevDat = dat;
            if (s.midStart && c == 200) startA = 1'b1;
            @(posedge clk);
            c++;
            #1 startA = 1'b0;
        end
        b = s.useB ? busyB : busyA;
        buildExpected(s.memCount, exp);
        mism = 0;
        eols = 0;
        for (int i = 0; i < rx.size(); i++) begin
            if (i >= exp.size() || rx[i] != exp[i]) mism++;
            if (rx[i] == 8'h0A) eols++;
        end
        check({s.name, "_bytes"}, rx.size(), s.expBytes);
        check({s.name, "_stream_mismatches"}, mism, 0);
        check({s.name, "_lines"}, eols, s.expBytes / 9);
        check({s.name, "_done_count"}, doneCnt, 1);
        if (s.expDone >= 0) check({s.name, "_done_cycle"}, doneCyc, s.expDone);
        if (s.readyPct < 100) check({s.name, "_stall_stability_violations"}, stallViol, 0);
        if (s.useB) check({s.name, "_memaddr_nonzero"}, memViol, 0);
        check({s.name, "_busy_after"}, b, 0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        bit found;
        string got;

        scen[0] = '{"regdump",   1'b0, 100, 1'b0, 1'b0, 16, 432, 480};
        scen[1] = '{"backpr30",  1'b0,  30, 1'b0, 1'b0, 16, 432,  -1};
        scen[2] = '{"midstart",  1'b0, 100, 1'b0, 1'b1, 16, 432, 480};
        scen[3] = '{"randdata",  1'b0,  60, 1'b1, 1'b0, 16, 432,  -1};
        scen[4] = '{"mc1",       1'b1, 100, 1'b0, 1'b0,  1, 297, 330};
        scen[5] = '{"mc1rand",   1'b1,  50, 1'b1, 1'b0,  1, 297,  -1};
        lines[0] = '{0,  "00000010\n"};
        lines[1] = '{1,  "DEAD0001\n"};
        lines[2] = '{31, "DEAD001F\n"};
        lines[3] = '{32, "0123ABEF\n"};
        lines[4] = '{47, "0123ABEF\n"};

        // Reset held with start and ready high: everything quiet.
        loadData(1'b0);
        rst = 1'b1; startA = 1'b1; startB = 1'b0; txReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", {txValidA, busyA, doneA, regAddrA, memAddrA},
                  {1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busyA, 1);
        check("post_reset_capture_valid", txValidA, 0);
        @(negedge clk);
        check("post_reset_first_byte", {txValidA, txDataA}, {1'b1, 8'h30});
        startA = 1'b0;
        pulseReset();

        for (int si = 0; si < 6; si++) begin
            runDump(si);
            if (si == 0) begin
                foreach (lines[j]) begin
                    got = "";
                    for (int k = 0; k < 9; k++)
                        if (lines[j].ln * 9 + k < rx.size())
                            got = $sformatf("%s%c", got, rx[lines[j].ln * 9 + k]);
                    checkStr($sformatf("line_%0d", lines[j].ln), got, lines[j].txt);
                end
            end
        end

        // start held high: a new dump starts right after done.
        loadData(1'b0);
        @(negedge clk);
        txReady = 1'b1;
        startA = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (doneA) found = 1'b1;
        end
        check("hold_start_done_seen", found, 1);
        @(negedge clk);
        check("hold_start_restart_busy", {busyA, txValidA}, {1'b1, 1'b0});
        @(negedge clk);
        check("hold_start_restart_byte", {txValidA, txDataA}, {1'b1, 8'h30});
        startA = 1'b0;
        pulseReset();

        // Abort during byte 100, then a clean dump.
        @(negedge clk);
        txReady = 1'b1;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (txValidA && cnt == 99) begin
                found = 1'b1;
                rst = 1'b1;
            end else begin
                if (txValidA) cnt++;
                @(negedge clk);
            end
        end
        check("abort_reached_byte100", found, 1);
        @(negedge clk);
        check("abort_valid_busy", {txValidA, busyA}, {1'b0, 1'b0});
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (doneA) cnt++;
        end
        check("abort_no_done", cnt, 0);
        runDump(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
